usbfs_tx_pkt: RTL and testbench

IN-endpoint packet stage for the full-speed USB device: sits directly downstream of the endpoint byte-writer, whose write-buffer port it receives. On an IN token it signals the endpoint to fill a MAX_PKT-byte buffer, then emits DATA0/DATA1 PID, payload and CRC16 as a byte stream to the bit-level transmitter. It holds the data for retransmission until the host ACKs, and owns the data toggle.

---
 rtl/usbfs_tx_pkt.sv | 184 ++++++++++++++++++
 tb/tb_usbfs_tx_pkt.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/usbfs_tx_pkt.sv
// rtl/usbfs_tx_pkt.sv - IN-endpoint packet stage: buffers one packet, streams PID/payload/CRC16, retransmits until ACK
module usbfs_tx_pkt #(
  parameter int MAX_PKT = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_inToken,
  input  logic                         i_ack,
  input  logic                         i_timeout,
  input  logic                         i_toggleClr,
  output logic                         o_etTxAccepted,
  input  logic                         i_etWrEn,
  input  logic [$clog2(MAX_PKT)-1:0]   i_etWrIdx,
  input  logic [7:0]                   i_etWrByte,
  input  logic [$clog2(MAX_PKT+1)-1:0] i_etWrNBytes,
  output logic                         o_txValid,
  input  logic                         i_txReady,
  output logic [7:0]                   o_txData,
  output logic                         o_txLast,
  output logic                         o_busy
);
  localparam int IDX_W = $clog2(MAX_PKT);
  localparam int LEN_W = $clog2(MAX_PKT + 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_PKT);

  typedef enum logic [2:0] {
    S_IDLE, S_ACCEPT, S_FILL, S_PID, S_DATA, S_CRCL, S_CRCH, S_WAITACK
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [IDX_W-1:0] rd_q, rd_d;
  logic [15:0]      crc_q, crc_d;
  logic             toggle_q, toggle_d;
  logic             retained_q, retained_d;
  logic             acc_q, acc_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             busy_q, busy_d;
  logic [7:0]       data_q, data_d;
  logic             mem_we, hs, load;
  logic [7:0]       pkt_mem_q [MAX_PKT];

  // Reflected CRC16 (poly 0x8005 -> 0xA001), one byte LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ b[i]) r = (r >> 1) ^ 16'hA001;
      else             r = r >> 1;
    end
    return r;
  endfunction

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    rd_d       = rd_q;
    crc_d      = crc_q;
    toggle_d   = toggle_q;
    retained_d = retained_q;
    mem_we     = 1'b0;
    hs         = valid_q && i_txReady;

    case (state_q)
      S_IDLE: begin
        if (i_inToken) state_d = (retained_q && !i_toggleClr) ? S_PID : S_ACCEPT;
      end
      S_ACCEPT: begin
        len_d   = '0;
        state_d = S_FILL;
      end
      S_FILL: begin
        if (len_q == LEN_MAX || !i_etWrEn) begin
          state_d = S_PID;
        end else begin
          mem_we = 1'b1;
          len_d  = len_q + 1'b1;
        end
      end
      S_PID: begin
        if (hs) begin
          rd_d    = '0;
          state_d = (len_q != '0) ? S_DATA : S_CRCL;
        end
      end
      S_DATA: begin
        if (hs) begin
          crc_d = crc16_byte(crc_q, pkt_mem_q[rd_q]);
          rd_d  = rd_q + 1'b1;
          if ({1'b0, rd_q} == len_q - 1'b1) state_d = S_CRCL;
        end
      end
      S_CRCL: if (hs) state_d = S_CRCH;
      S_CRCH: if (hs) state_d = S_WAITACK;
      S_WAITACK: begin
        if (i_ack) begin
          toggle_d   = !toggle_q;
          retained_d = 1'b0;
          state_d    = S_IDLE;
        end else if (i_timeout) begin
          retained_d = 1'b1;
          state_d    = S_IDLE;
        end else if (i_inToken) begin
          state_d = S_PID;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_PID && state_q != S_PID) crc_d = 16'hFFFF;
    if (i_toggleClr) begin
      toggle_d   = 1'b0;
      retained_d = 1'b0;
    end

    acc_d   = (state_d == S_ACCEPT);
    busy_d  = (state_d != S_IDLE);
    valid_d = state_d inside {S_PID, S_DATA, S_CRCL, S_CRCH};

    // Output byte only advances when the current one is consumed, so it holds under back-pressure.
    load   = !valid_q || hs;
    data_d = data_q;
    last_d = last_q;
    if (load) begin
      last_d = (state_d == S_CRCH);
      case (state_d)
        S_PID:   data_d = toggle_d ? 8'h4B : 8'hC3;
        S_DATA:  data_d = pkt_mem_q[rd_d];
        S_CRCL:  data_d = ~crc_d[7:0];
        S_CRCH:  data_d = ~crc_d[15:8];
        default: data_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      rd_q       <= '0;
      crc_q      <= 16'hFFFF;
      toggle_q   <= 1'b0;
      retained_q <= 1'b0;
      acc_q      <= 1'b0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      data_q     <= 8'h00;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      rd_q       <= rd_d;
      crc_q      <= crc_d;
      toggle_q   <= toggle_d;
      retained_q <= retained_d;
      acc_q      <= acc_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      busy_q     <= busy_d;
      data_q     <= data_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (mem_we) pkt_mem_q[i_etWrIdx] <= i_etWrByte;
  end

  always @(posedge i_clk) begin
    if (state_q == S_FILL && i_etWrEn && len_q != LEN_MAX)
      assert (i_etWrIdx == len_q[IDX_W-1:0]);
    if (i_etWrEn)
      assert (state_q == S_FILL);
    if (state_q == S_FILL && state_d == S_PID)
      assert (i_etWrNBytes == len_q);
  end

  assign o_etTxAccepted = acc_q;
  assign o_txValid      = valid_q;
  assign o_txData       = data_q;
  assign o_txLast       = last_q;
  assign o_busy         = busy_q;

endmodule

// File: tb/tb_usbfs_tx_pkt.sv
// tb/tb_usbfs_tx_pkt.sv - scoreboard bench for usbfs_tx_pkt
module tb_usbfs_tx_pkt;
  logic       clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_inToken = 1'b0, i_ack = 1'b0, i_timeout = 1'b0, i_toggleClr = 1'b0;
  logic       o_etTxAccepted;
  logic       i_etWrEn = 1'b0;
  logic [2:0] i_etWrIdx = '0;
  logic [7:0] i_etWrByte = '0;
  logic [3:0] i_etWrNBytes = '0;
  logic       o_txValid;
  logic       i_txReady = 1'b1;
  logic [7:0] o_txData;
  logic       o_txLast;
  logic       o_busy;

  usbfs_tx_pkt #(.MAX_PKT(8)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_inToken(i_inToken), .i_ack(i_ack),
    .i_timeout(i_timeout), .i_toggleClr(i_toggleClr), .o_etTxAccepted(o_etTxAccepted),
    .i_etWrEn(i_etWrEn), .i_etWrIdx(i_etWrIdx), .i_etWrByte(i_etWrByte),
    .i_etWrNBytes(i_etWrNBytes), .o_txValid(o_txValid), .i_txReady(i_txReady),
    .o_txData(o_txData), .o_txLast(o_txLast), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  logic [8:0] sb[$];
  int   n_checks = 0, n_pass = 0, n_fail = 0;
  int   acc_cnt = 0, hs_cnt = 0;
  bit   rnd_ready = 1'b0;
  bit   exp_tog = 1'b0;
  logic prev_stall = 1'b0, prev_last = 1'b0;
  logic [7:0] prev_data = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] crc_ref(input logic [7:0] d[$]);
    logic [15:0] c, r;
    logic fb;
    c = 16'hFFFF;
    foreach (d[i]) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[15] ^ d[i][b];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h8005;
      end
    end
    for (int k = 0; k < 16; k++) r[k] = c[15-k];
    return ~r;
  endfunction

  always @(posedge clk) begin
    #1 i_txReady = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    logic [8:0] e;
    if (o_etTxAccepted) acc_cnt++;
    if (prev_stall)
      check("stall_hold", {o_txValid, o_txLast, o_txData}, {1'b1, prev_last, prev_data});
    prev_stall = o_txValid && !i_txReady;
    prev_data  = o_txData;
    prev_last  = o_txLast;
    if (o_txValid && i_txReady) begin
      hs_cnt++;
      check("sb_has_entry", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check($sformatf("byte%0d", hs_cnt), {o_txLast, o_txData}, e);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pkt(input logic [7:0] d[$], input bit tog);
    logic [15:0] c;
    c = crc_ref(d);
    sb.push_back({1'b0, tog ? 8'h4B : 8'hC3});
    foreach (d[i]) sb.push_back({1'b0, d[i]});
    sb.push_back({1'b0, c[7:0]});
    sb.push_back({1'b1, c[15:8]});
  endtask

  task automatic start_new(input logic [7:0] d[$], input string tag);
    push_pkt(d, exp_tog);
    i_inToken = 1'b1;
    tick();
    i_inToken = 1'b0;
    check({tag, "_accept_pulse"}, o_etTxAccepted, 1);
    tick();
    foreach (d[i]) begin
      i_etWrEn     = 1'b1;
      i_etWrIdx    = 3'(i);
      i_etWrByte   = d[i];
      i_etWrNBytes = 4'(i);
      tick();
    end
    i_etWrEn     = 1'b0;
    i_etWrNBytes = 4'(d.size());
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || o_txValid) && n < 300) begin
      tick();
      n++;
    end
    check({tag, "_drain"}, sb.size(), 0);
    check({tag, "_stream_idle"}, o_txValid, 0);
    check({tag, "_busy_waitack"}, o_busy, 1);
  endtask

  task automatic send_new(input logic [7:0] d[$], input string tag);
    int a0;
    a0 = acc_cnt;
    start_new(d, tag);
    drain(tag);
    check({tag, "_accept_count"}, acc_cnt - a0, 1);
  endtask

  task automatic do_ack(input bit clr);
    i_ack       = 1'b1;
    i_toggleClr = clr;
    tick();
    i_ack       = 1'b0;
    i_toggleClr = 1'b0;
    exp_tog     = clr ? 1'b0 : ~exp_tog;
    check("ack_idle", o_busy, 0);
  endtask

  initial begin
    logic [7:0] pkt[$];
    int a0, h0, n;

    repeat (3) tick();
    check("rst_valid", o_txValid, 0);
    check("rst_data", o_txData, 0);
    check("rst_last", o_txLast, 0);
    check("rst_busy", o_busy, 0);
    check("rst_accept", o_etTxAccepted, 0);
    i_rst = 1'b0;
    tick();

    pkt = {};
    send_new(pkt, "zlp");
    do_ack(1'b0);

    pkt = {};
    for (int i = 0; i < 8; i++) pkt.push_back(8'(i));
    send_new(pkt, "full");
    do_ack(1'b0);

    rnd_ready = 1'b1;
    pkt = {8'h11, 8'h22, 8'h33};
    send_new(pkt, "bp");
    rnd_ready = 1'b0;
    do_ack(1'b0);

    pkt = {8'hAA, 8'hBB};
    send_new(pkt, "rtx");
    i_timeout = 1'b1;
    tick();
    i_timeout = 1'b0;
    check("timeout_idle", o_busy, 0);
    a0 = acc_cnt;
    push_pkt(pkt, exp_tog);
    i_inToken = 1'b1;
    tick();
    i_inToken = 1'b0;
    check("rtx_pid_immediate", {o_txValid, o_txData}, {1'b1, 8'h4B});
    drain("rtx2");
    check("rtx_no_accept", acc_cnt - a0, 0);
    do_ack(1'b0);

    pkt = {8'h5A};
    send_new(pkt, "d0");
    do_ack(1'b0);
    i_toggleClr = 1'b1;
    tick();
    i_toggleClr = 1'b0;
    exp_tog = 1'b0;
    pkt = {8'h01, 8'h02};
    send_new(pkt, "clr");
    do_ack(1'b1);
    pkt = {8'h03};
    send_new(pkt, "ackclr");

    a0 = acc_cnt;
    i_ack     = 1'b1;
    i_inToken = 1'b1;
    tick();
    i_ack     = 1'b0;
    i_inToken = 1'b0;
    exp_tog   = ~exp_tog;
    repeat (3) tick();
    check("ack_tok_idle", o_busy, 0);
    check("ack_tok_no_stream", o_txValid, 0);
    check("ack_tok_no_accept", acc_cnt - a0, 0);

    pkt = {8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
    h0 = hs_cnt;
    start_new(pkt, "rstmid");
    n = 0;
    while (hs_cnt < h0 + 3 && n < 50) begin
      tick();
      n++;
    end
    check("rstmid_byte2", {o_txValid, o_txData}, {1'b1, 8'h30});
    #1 i_rst = 1'b1;
    #1;
    check("rstmid_valid", o_txValid, 0);
    check("rstmid_busy", o_busy, 0);
    sb.delete();
    prev_stall = 1'b0;
    tick();
    tick();
    i_rst   = 1'b0;
    exp_tog = 1'b0;
    tick();
    pkt = {8'h77};
    send_new(pkt, "post_rst");
    do_ack(1'b0);

    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
